// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants and types for the SHA-256 core.
//   WORD_W      : 32-bit word width
//   BLOCK_WORDS : 16 message words per 512-bit block
//   ROUNDS      : 64 schedule words / compression rounds
//   word_t      : one 32-bit word
//   state_t     : message-schedule FSM states
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int ROUNDS      = 64;
    localparam int IDX_W       = $clog2(ROUNDS);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GEN
    } state_t;

endpackage

// File: rtl/sha256_w_next.sv
// ---------------------------------------------------------------------------
// sha256_w_next
// Combinational next-word generator for the 16-word schedule window:
//   o_next = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t]  (mod 2^32)
// Ports:
//   i_w0  : window[0]  (W[t])
//   i_w1  : window[1]  (W[t+1])
//   i_w9  : window[9]  (W[t+9])
//   i_w14 : window[14] (W[t+14])
//   o_next: W[t+16]
// ---------------------------------------------------------------------------
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_w0,
    input  logic [WORD_W-1:0] i_w1,
    input  logic [WORD_W-1:0] i_w9,
    input  logic [WORD_W-1:0] i_w14,
    output logic [WORD_W-1:0] o_next
);

    word_t w_s0;
    word_t w_s1;

    sigma0 u_sigma0 (
        .i_x (i_w1),
        .o_y (w_s0)
    );

    sigma1 u_sigma1 (
        .i_x (i_w14),
        .o_y (w_s1)
    );

    // The sum is held in a 32-bit result, so carries out of bit 31 drop off
    // and the addition wraps modulo 2^32 as the algorithm requires.
    assign o_next = w_s1 + i_w9 + w_s0 + i_w0;

endmodule

// File: rtl/sigma0.sv
// ---------------------------------------------------------------------------
// sigma0
// Small sigma0 of the SHA-256 message schedule:
//   ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
// Ports:
//   i_x : input word
//   o_y : sigma0(i_x)
// ---------------------------------------------------------------------------
module sigma0
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    assign o_y = {i_x[6:0],  i_x[31:7]}
               ^ {i_x[17:0], i_x[31:18]}
               ^ {3'b000,    i_x[31:3]};

endmodule

// File: rtl/sigma1.sv
// ---------------------------------------------------------------------------
// sigma1
// Small sigma1 of the SHA-256 message schedule:
//   ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
// Ports:
//   i_x : input word
//   o_y : sigma1(i_x)
// ---------------------------------------------------------------------------
module sigma1
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    assign o_y = {i_x[16:0],  i_x[31:17]}
               ^ {i_x[18:0],  i_x[31:19]}
               ^ {10'b0,      i_x[31:10]};

endmodule

// File: rtl/sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha256_msg_schedule
// Accepts one 512-bit block as 16 big-endian words and streams the 64
// schedule words W[0..63], one per valid/ready handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins a new block (sampled only in IDLE)
//   in_valid / in_ready / in_word : message-word input handshake
//   w_valid / w_ready / w_out     : schedule-word output handshake
//   w_idx      : round index of w_out
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse after W[63] is taken
// ---------------------------------------------------------------------------
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [IDX_W-1:0]  w_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_LOAD  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_done;
    word_t             r_window [BLOCK_WORDS];

    word_t             w_next;
    word_t             w_fill;
    logic              w_in_take;
    logic              w_out_take;
    logic              w_shift;

    sha256_w_next u_w_next (
        .i_w0   (r_window[0]),
        .i_w1   (r_window[1]),
        .i_w9   (r_window[9]),
        .i_w14  (r_window[14]),
        .o_next (w_next)
    );

    // Loading and generating use the same shift; only the word entering
    // slot 15 differs.
    always_comb begin
        w_in_take  = (r_state == LOAD) && in_valid;
        w_out_take = (r_state == GEN)  && w_ready;
        w_shift    = w_in_take || w_out_take;
        w_fill     = (r_state == LOAD) ? in_word : w_next;
    end

    // NOTE: the window is reset even though it is storage, because w_out
    // reads window[0] directly and must show 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                r_window[k] <= '0;
            end
        end else if (w_shift) begin
            for (int k = 0; k < BLOCK_WORDS - 1; k++) begin
                r_window[k] <= r_window[k+1];
            end
            r_window[BLOCK_WORDS-1] <= w_fill;
        end
    end

    // NOTE: r_done gets a default of 0 first and is overridden later in the
    // same block; with non-blocking assignments the last write wins, which
    // makes it a clean single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == LAST_LOAD) begin
                            r_state <= GEN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                GEN: begin
                    if (w_ready) begin
                        if (r_cnt == LAST_ROUND) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready = (r_state == LOAD);
    assign w_valid  = (r_state == GEN);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign w_out    = r_window[0];
    assign w_idx    = r_cnt;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Self-checking bench for sha256_msg_schedule. Expected schedule words come
// from a direct array formulation of the SHA-256 schedule recurrence.
// ---------------------------------------------------------------------------
module tb_sha256_msg_schedule;
    import sha256_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              w_valid;
    logic              w_ready;
    logic [WORD_W-1:0] w_out;
    logic [IDX_W-1:0]  w_idx;
    logic              busy;
    logic              done;

    sha256_msg_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic void build_ref(input logic [15:0][31:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = blk[t];
            else        ref_w[t] = ref_s1(ref_w[t-2]) + ref_w[t-7]
                                 + ref_s0(ref_w[t-15]) + ref_w[t-16];
        end
    endfunction

    function automatic logic [15:0][31:0] rand_block();
        logic [15:0][31:0] b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    // ---------------- stimulus tasks (called at a negedge) ----------------
    task automatic load_block(input logic [15:0][31:0] blk, input bit do_start,
                              input bit gaps, input bit stray);
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        check("in_ready_after_start", in_ready, 1);
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                in_word  = $urandom;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_word  = blk[i];
            start    = stray && (i == 5);
            @(negedge clk);
        end
        start    = 1'b0;
        // Keep offering a poison word: a 17th word must never be consumed.
        in_valid = 1'b1;
        in_word  = 32'hDEADBEEF;
        check("in_ready_after_load", in_ready, 0);
        check("w_valid_after_load", w_valid, 1);
    endtask

    task automatic collect(input int n_words, input int stall_idx, input int stall_len,
                           input bit stray, input bit chain);
        int taken   = 0;
        int stalled = 0;
        int cyc     = 0;
        while (taken < n_words && cyc < 1000) begin
            cyc++;
            start = 1'b0;
            if (w_valid) begin
                check("w_idx", 32'(w_idx), taken);
                check("w_out", w_out, ref_w[taken]);
                got_w[taken] = w_out;
                if (taken == stall_idx && stalled < stall_len) begin
                    w_ready = 1'b0;
                    stalled++;
                end else begin
                    w_ready = 1'b1;
                    taken++;
                end
                if (stray && taken == 40) start = 1'b1;
            end else begin
                w_ready = 1'b0;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        w_ready  = 1'b0;
        in_valid = 1'b0;
        if (taken < n_words) check("collect_timeout", taken, n_words);
        if (n_words == 64) begin
            check("done_pulse", done, 1);
            check("busy_at_done", busy, 0);
            check("w_valid_at_done", w_valid, 0);
            start = chain;
            @(negedge clk);
            start = 1'b0;
            check("done_once", done, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_w_valid"},  w_valid,  0);
        check({tag, "_w_out"},    w_out,    0);
        check({tag, "_w_idx"},    32'(w_idx), 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0][31:0] blk;
        bit                gaps;
        logic [31:0]       w16;
        logic [31:0]       w17;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [15:0][31:0] abc_blk;
        logic [15:0][31:0] ones_blk;
        logic [15:0][31:0] blk_a;
        logic [15:0][31:0] blk_b;

        abc_blk     = '0;
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        ones_blk    = '1;

        vecs[0] = '{blk: abc_blk,  gaps: 1'b0, w16: 32'h61626380, w17: 32'h000F0000};
        vecs[1] = '{blk: abc_blk,  gaps: 1'b1, w16: 32'h61626380, w17: 32'h000F0000};
        vecs[2] = '{blk: ones_blk, gaps: 1'b0, w16: 32'h203FFFFC, w17: 32'h203FFFFC};
        vecs[3] = '{blk: ones_blk, gaps: 1'b1, w16: 32'h203FFFFC, w17: 32'h203FFFFC};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        w_ready  = 1'b0;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven blocks: abc and all-ones, with and without input gaps.
        for (int v = 0; v < 4; v++) begin
            build_ref(vecs[v].blk);
            load_block(vecs[v].blk, 1'b1, vecs[v].gaps, 1'b0);
            collect(64, -1, 0, 1'b0, 1'b0);
            check("table_w0",  got_w[0],  vecs[v].blk[0]);
            check("table_w15", got_w[15], vecs[v].blk[15]);
            check("table_w16", got_w[16], vecs[v].w16);
            check("table_w17", got_w[17], vecs[v].w17);
        end

        // Backpressure at w_idx=20, stray starts in LOAD and GEN, start in
        // the done cycle chaining straight into a second random block.
        blk_a = rand_block();
        build_ref(blk_a);
        load_block(blk_a, 1'b1, 1'b0, 1'b1);
        collect(64, 20, 5, 1'b1, 1'b1);
        blk_b = rand_block();
        build_ref(blk_b);
        load_block(blk_b, 1'b0, 1'b0, 1'b0);
        collect(64, -1, 0, 1'b0, 1'b0);

        // Reset in the middle of generation.
        blk_a = rand_block();
        build_ref(blk_a);
        load_block(blk_a, 1'b1, 1'b0, 1'b0);
        collect(30, -1, 0, 1'b0, 1'b0);
        check("pre_reset_w_idx", 32'(w_idx), 30);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_word  = $urandom;
        repeat (5) begin
            @(negedge clk);
            check("no_accept_in_ready", in_ready, 0);
            check("no_accept_busy", busy, 0);
        end
        in_valid = 1'b0;

        // Recovery: a fresh random block after reset.
        blk_b = rand_block();
        build_ref(blk_b);
        load_block(blk_b, 1'b1, 1'b1, 1'b0);
        collect(64, 7, 3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
